// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial-product add per clock through a
// 2N-bit ripple-carry chain. Define EARLY_TERM_EN to exit RUN once the multiplier runs out of ones.
module seq_shift_add_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  product_q, product_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2*N-1:0]  addend, sum;
  logic            last_iter;

  assign addend = mplier_q[0] ? mcand_q : '0;

  // Ripple chain of single-bit full adders, carry-in 0; the final carry-out is always 0 for
  // unsigned N x N operands and is dropped.
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      sum[i] = acc_q[i] ^ addend[i] ^ carry;
      carry  = (acc_q[i] & addend[i]) | (carry & (acc_q[i] ^ addend[i]));
    end
  end

`ifdef EARLY_TERM_EN
  assign last_iter = (count_q == CntW'(N - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_iter = (count_q == CntW'(N - 1));
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        if (last_iter) begin
          product_d = sum;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench for seq_shift_add_multiplier (N=8); iteration counts follow
// EARLY_TERM_EN when it is defined.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;
  bit overlap = 1'b0;

  seq_shift_add_multiplier #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_iters(input logic [7:0] bv);
`ifdef EARLY_TERM_EN
    int k = 1;
    for (int i = 0; i < 8; i++) if (bv[i]) k = i + 1;
    return k;
`else
    return 8;
`endif
  endfunction

  // Counts RUN cycles sampled on negedges until done is seen, bounded.
  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_prod);
    int cyc;
    bit seen;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'hA5;
    b = 8'h3C;
    wait_done(cyc, seen);
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " busy cycles"}, 32'(cyc), 32'(exp_iters(bv)));
    check({tag, " product"}, 32'(product), 32'(exp_prod));
    @(negedge clk);
    check({tag, " done falls"}, 32'(done), 32'd0);
    check({tag, " product holds"}, 32'(product), 32'(exp_prod));
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle without start", 32'(busy), 32'd0);

    run_op("13x11", 8'd13, 8'd11, 16'd143);
    run_op("255x255", 8'd255, 8'd255, 16'hFE01);
    run_op("5Ax0", 8'h5A, 8'd0, 16'd0);
    run_op("200x1", 8'd200, 8'd1, 16'd200);
    run_op("3x80", 8'd3, 8'h80, 16'd384);

    // Mid-RUN start is ignored; start held through DONE is accepted one edge after DONE.
    a = 8'd6;
    b = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("6x7 busy", 32'(busy), 32'd1);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    wait_done(cyc, seen);
    check("6x7 done seen", 32'(seen), 32'd1);
    check("6x7 busy cycles", 32'(cyc + 1), 32'(exp_iters(8'd7)));
    check("6x7 product", 32'(product), 32'd42);
    @(negedge clk);
    check("after done busy", 32'(busy), 32'd0);
    check("after done done", 32'(done), 32'd0);
    check("after done product", 32'(product), 32'd42);
    @(negedge clk);
    check("held start accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(cyc, seen);
    check("9x9 done seen", 32'(seen), 32'd1);
    check("9x9 busy cycles", 32'(cyc + 1), 32'(exp_iters(8'd9)));
    check("9x9 product", 32'(product), 32'd81);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    a = 8'd100;
    b = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset product", 32'(product), 32'd81);
    rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", 32'(busy), 32'd0);
    run_op("12x12", 8'd12, 8'd12, 16'd144);

    check("busy/done overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
Sequential N-bit unsigned shift-and-add multiplier, one partial-product add per clock.
- Its 2N-bit adder is a ripple-carry chain of the team's existing single-bit full-adder cells; this block is the sequencing stage that feeds that chain and consumes its sum/carry outputs.
- Start/done handshake toward the surrounding design.
- Registered 2N-bit product output.

Parameters:
N, 8, operand width in bits; product is 2N bits; N >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  N  multiplicand; captured on the accepted start edge
b  input  N  multiplier; captured on the accepted start edge
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; product is valid from this cycle onward
product  output  2N  registered result; holds its value until the next completion

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- Reset asserted mid-operation aborts the operation immediately. After reset release, a new start is required.
- Internal registers:
  - mcand (2N bits): zero-extended a, shifted left 1 bit per iteration.
  - mplier (N bits): b, shifted right 1 bit per iteration.
  - acc (2N bits).
  - count (ceil(log2 N) bits).
- IDLE:
  - start=1 on a clock edge: mcand<={0,a}, mplier<=b, acc<=0, count<=0, state<=RUN.
  - start=0: remain in IDLE.
  - a and b are don't-care outside the accepting edge.
- RUN, on each edge:
  - acc <= acc + (mplier[0] ? mcand : 0), computed through the 2N-bit full-adder chain with carry-in 0. The carry-out is discarded; it is provably 0 for unsigned N x N operands.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count+1.
  - If the exit condition holds: product <= new acc value, state <= DONE.
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE unconditionally. start is ignored in DONE; earliest acceptance is the edge after DONE.
- start asserted in RUN or DONE is ignored; operands are not re-captured.
- Exit condition (base): count==N-1, i.e. after N iterations. Latency: done is high in the cycle following the N-th edge after the start edge. Throughput is one multiply per N+2 cycles.
- busy=1 exactly in RUN; busy and done are never high together.
- product changes only on the edge entering DONE, or on reset.

Optional Feature:
EARLY_TERM_EN
- Defined: RUN also exits when the shifted mplier value (mplier>>1) is 0. Latency = index of the highest set bit of b, plus 1; b=0 completes in 1 iteration. product is identical to the base result.
- Undefined: every operation takes exactly N iterations regardless of operand values.

Test Plan:
- N=8, a=13, b=11, start pulsed 1 cycle -> busy high 8 cycles; done pulses once; product=143; product holds 143 after done falls.
- N=8, a=255, b=255 -> product=65025 (0xFE01); exercises full carry propagation through the chain.
- N=8, a=0x5A, b=0 -> product=0. Without EARLY_TERM_EN, done after 8 iterations; with it, done after 1 iteration.
- With EARLY_TERM_EN, a=200, b=1 -> done after 1 iteration, product=200. a=3, b=0x80 -> done after 8 iterations, product=384.
- a=6, b=7 started; mid-RUN raise start with a=9, b=9 -> ignored; product=42. Start held high through DONE -> new operation begins on the edge after DONE (entering IDLE) and is accepted on the following edge.
- Start a=100, b=100; assert rst at iteration 4 -> busy, done, and product go 0 immediately, asynchronously. Release, start a=12, b=12 -> product=144.
